// File: rtl/axis_burst_packer.sv
// rtl/axis_burst_packer.sv - frames wide capture bursts as header/data/trailer packets on a narrow stream
module axis_burst_packer #(
  parameter int          NUM_CHANNELS  = 4,
  parameter int          CHANNEL_WIDTH = 64,
  parameter int          BURST_LENGTH  = 32,
  parameter int          OUT_WIDTH     = 32,
  parameter logic [15:0] HEADER_MAGIC  = 16'hA55A,
  localparam int         DATA_WIDTH    = NUM_CHANNELS * CHANNEL_WIDTH,
  localparam int         RATIO         = DATA_WIDTH / OUT_WIDTH,
  localparam int         SW            = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tlast
);

  typedef enum logic [2:0] {
    S_IDLE, S_H0, S_H1, S_LOAD, S_SER, S_TRL
  } state_t;

  state_t                state, next_state;
  logic [15:0]           seq;
  logic [31:0]           ts, ts_lat;
  logic [15:0]           beat_cnt, beat_nxt;
  logic                  err_short, err_long, last_q;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic [SW-1:0]         slice_cnt;
  logic                  m_hs, s_hs, last_slice, close_pkt;

  assign m_hs       = m_axis_tvalid && m_axis_tready;
  assign s_hs       = s_axis_tvalid && s_axis_tready;
  assign last_slice = (slice_cnt == SW'(RATIO - 1));
  assign close_pkt  = last_q || (beat_cnt == 16'(BURST_LENGTH));
  assign beat_nxt   = beat_cnt + 16'd1;
  assign shift_nxt  = shift_reg >> OUT_WIDTH;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (s_axis_tvalid) next_state = S_H0;
      S_H0:   if (m_hs) next_state = S_H1;
      S_H1:   if (m_hs) next_state = S_LOAD;
      S_LOAD: if (s_hs) next_state = S_SER;
      S_SER:  if (m_hs && last_slice) next_state = close_pkt ? S_TRL : S_LOAD;
      S_TRL:  if (m_hs) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = (state == S_LOAD);
  end

  // Output word, valid and last are registered from the next state so the
  // word is already on the bus in the cycle the FSM enters a sending state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      seq           <= '0;
      ts            <= '0;
      ts_lat        <= '0;
      beat_cnt      <= '0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
      last_q        <= 1'b0;
      shift_reg     <= '0;
      slice_cnt     <= '0;
    end else begin
      ts            <= ts + 32'd1;
      m_axis_tvalid <= (next_state == S_H0) || (next_state == S_H1) ||
                       (next_state == S_SER) || (next_state == S_TRL);
      m_axis_tlast  <= (next_state == S_TRL);
      case (state)
        S_IDLE: begin
          if (s_axis_tvalid) begin
            ts_lat       <= ts;
            m_axis_tdata <= OUT_WIDTH'({HEADER_MAGIC, seq});
          end
        end
        S_H0: begin
          if (m_hs) m_axis_tdata <= OUT_WIDTH'(ts_lat);
        end
        S_LOAD: begin
          if (s_hs) begin
            shift_reg    <= s_axis_tdata;
            m_axis_tdata <= s_axis_tdata[OUT_WIDTH-1:0];
            slice_cnt    <= '0;
            beat_cnt     <= beat_nxt;
            last_q       <= s_axis_tlast;
            err_short    <= err_short | (s_axis_tlast && (beat_nxt < 16'(BURST_LENGTH)));
            err_long     <= err_long | (!s_axis_tlast && (beat_nxt == 16'(BURST_LENGTH)));
          end
        end
        S_SER: begin
          if (m_hs) begin
            if (last_slice) begin
              if (close_pkt)
                m_axis_tdata <= OUT_WIDTH'({err_short, err_long, 14'b0, beat_cnt});
            end else begin
              slice_cnt    <= slice_cnt + SW'(1);
              shift_reg    <= shift_nxt;
              m_axis_tdata <= shift_nxt[OUT_WIDTH-1:0];
            end
          end
        end
        S_TRL: begin
          if (m_hs) begin
            seq       <= seq + 16'd1;
            beat_cnt  <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axis_burst_packer.md
# axis_burst_packer

Packetiser that sits directly downstream of the multi-channel peak detector. It takes each captured burst (wide AXI-stream beats terminated by tlast) and frames it with a header and a trailer. It serialises the result onto a narrow AXI-stream toward the host-interface FIFO. Each burst becomes one self-describing packet that carries a sequence number, a capture timestamp and integrity flags.

## Interface
- NUM_CHANNELS, 4, channels per input beat
- CHANNEL_WIDTH, 64, bits per channel
- BURST_LENGTH, 32, expected beats per burst; power of two, ≤ 65535
- OUT_WIDTH, 32, output word width; must divide DATA_WIDTH
- HEADER_MAGIC, 16'hA55A, sync pattern in header word 0
- DATA_WIDTH (local), NUM_CHANNELS*CHANNEL_WIDTH
- RATIO (local), DATA_WIDTH/OUT_WIDTH, output words per input beat (default 8)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted
- s_axis_tdata  in  DATA_WIDTH  burst sample beat (channel 0 in LSBs)
- s_axis_tlast  in  1  final beat of burst
- m_axis_tvalid  out  1  output word valid (registered)
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  OUT_WIDTH  output word (registered)
- m_axis_tlast  out  1  final word of packet (registered)

## Operation
- Packet layout, in order:
  - H0 = {HEADER_MAGIC, seq[15:0]}
  - H1 = ts[31:0]
  - for each accepted beat, RATIO words, least-significant slice first
  - T = {err_short, err_long, 14'b0, beat_cnt[15:0]}
- seq: 16-bit counter. Increments by 1 when T is accepted. Wraps 0xFFFF→0.
- ts: 32-bit free-running cycle counter. Wraps. It is latched on the IDLE→H0 transition.
- FSM states:
  - IDLE: s_axis_tready=0. If s_axis_tvalid=1, latch ts, load H0, go to H0.
  - H0: on output handshake, load H1, go to H1.
  - H1: on handshake, go to LOAD.
  - LOAD: s_axis_tready=1 for exactly this state.
    - On input handshake, capture the beat into the shift register, increment beat_cnt, record tlast, present slice 0, go to SER.
    - LOAD holds indefinitely while s_axis_tvalid=0.
  - SER: each output handshake shifts the register by OUT_WIDTH and presents the next slice. After the RATIO-th handshake:
    - if the captured tlast=1 or beat_cnt==BURST_LENGTH, load T and go to TRL;
    - otherwise go to LOAD.
  - TRL: m_axis_tlast=1. On handshake, increment seq, clear beat_cnt and both error flags, go to IDLE.
- Error flags:
  - err_short=1 when tlast arrives with beat_cnt<BURST_LENGTH.
  - err_long=1 when beat_cnt reaches BURST_LENGTH with tlast=0. The burst closes anyway. The next beat begins a new packet.
- Slice counter width: log2(RATIO). beat_cnt width: 16 bits.
- AXI rules:
  - m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tvalid never drops without a handshake.
  - m_axis_tvalid=0 only in IDLE and LOAD.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, seq=0, ts=0, beat_cnt=0, error flags=0.
- Reset asserted mid-packet aborts the packet immediately. The next edge with rst_n=1 starts from IDLE and no partial trailer is emitted.
- Latency:
  - s_axis_tvalid high at edge k in IDLE → H0 valid from cycle k+1.
  - Accepted beat at edge j → slice 0 valid from cycle j+1.
- Throughput, with m_axis_tready held at 1:
  - one output word per cycle inside H0/H1/SER/TRL;
  - one bubble cycle per beat (LOAD);
  - default packet = 259 words in 291 cycles.
- Output handshake and state advance happen on the same edge. Back-to-back words need no bubble.
- A beat offered in IDLE is not consumed until LOAD. Its tvalid only triggers the header.

## Test plan
- Nominal burst: 32 beats, tlast on beat 31, beat n = replicated 32'(n), m_axis_tready=1. Expect 259 words:
  - H0=0xA55A0000, H1=ts, 256 data words, T=0x00000020 with tlast on T only.
- Backpressure: same burst with m_axis_tready toggled by an LFSR. Expect identical word sequence, data stable during stalls, no duplicated or dropped words.
- Short burst: tlast on beat 4. Expect 2+5*8+1=43 words and T=0x80000005.
- Long burst: 40 beats, no tlast. Expect:
  - packet 1 with T=0x40000020;
  - packet 2 with H0=0xA55A0001 and 8 beats (incomplete, no T until tlast supplied).
- Sequence wrap: preload or run 65536 packets. Expect seq 0xFFFF followed by 0x0000. Also expect ts strictly increasing between consecutive H1 words (mod 2^32).
- Reset mid-SER: drop rst_n for one cycle during slice 3. Expect:
  - next cycle m_axis_tvalid=0, s_axis_tready=0;
  - next packet H0=0xA55A0000.
